tone_sequencer: RTL and testbench

//  Note scheduler that sequences the triangle waveform generator. Buffers queued notes {invslope, duration}.

---
 rtl/tone_seq_pkg.sv | 20 ++
 rtl/tone_seq_fifo.sv | 45 ++++
 rtl/tone_sequencer.sv | 156 +++++++++++++++
 tb/tb_tone_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_seq_pkg.sv
// Shared types for the tone sequencer: FSM states, the queued note
// record and the data widths that tie it to the triangle generator.
package tone_seq_pkg;

    localparam int CTR_SIZE = 8;
    localparam int DUR_W    = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP
    } state_t;

    typedef struct packed {
        logic [CTR_SIZE-1:0] slope;
        logic [DUR_W-1:0]    dur;
    } note_t;

endpackage

// File: rtl/tone_seq_fifo.sv
// Note queue: DEPTH-entry synchronous FIFO of note_t with wrap-around
// pointers and a registered occupancy count.
module tone_seq_fifo
    import tone_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  note_t                  din,
    input  logic                   pop,
    output note_t                  dout,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    note_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/tone_sequencer.sv
// Note scheduler for the triangle generator. Define TONE_SEQ_GAP_EN
// to insert GAP_CYC silent cycles after every completed note.
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int TICK_DIV = 1000,
    parameter int GAP_CYC  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   note_valid,
    output logic                   note_ready,
    input  logic [CTR_SIZE-1:0]    note_slope,
    input  logic [DUR_W-1:0]       note_dur,
    input  logic                   start,
    input  logic                   stop,
    output logic [CTR_SIZE-1:0]    invslope,
    output logic                   tone_en,
    output logic                   note_done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [LW-1:0] FULL      = LW'(DEPTH);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_PRE  = TW'(TICK_DIV - 2);
    localparam logic [DUR_W-1:0] ONE    = DUR_W'(1);

    if (TICK_DIV < 2 || GAP_CYC < 1 || DEPTH < 2 ||
        (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("tone_sequencer: unsupported parameter set");
    end

    state_t            state;
    note_t             head;
    note_t             in_note;
    logic              run;
    logic              run_nxt;
    logic              push;
    logic              pop;
    logic              more;
    logic [TW-1:0]     tick_cnt;
    logic [DUR_W-1:0]  dur_cnt;

`ifdef TONE_SEQ_GAP_EN
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    logic [GW-1:0] gap_cnt;
`endif

    assign in_note    = '{slope: note_slope, dur: note_dur};
    assign note_ready = (level < FULL);
    assign push       = note_valid & note_ready;
    assign pop        = (state == LOAD);
    assign run_nxt    = (run | start) & ~stop;
    assign more       = run_nxt & (level != '0);

    tone_seq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (in_note),
        .pop   (pop),
        .dout  (head),
        .level (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            run       <= 1'b0;
            invslope  <= '0;
            tone_en   <= 1'b0;
            note_done <= 1'b0;
            busy      <= 1'b0;
            tick_cnt  <= '0;
            dur_cnt   <= '0;
`ifdef TONE_SEQ_GAP_EN
            gap_cnt   <= '0;
`endif
        end else begin
            run       <= run_nxt;
            note_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (more) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    // the head is popped either way; stop simply drops it
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state    <= PLAY;
                        tone_en  <= 1'b1;
                        invslope <= head.slope;
                        dur_cnt  <= (head.dur == '0) ? ONE : head.dur;
                        tick_cnt <= '0;
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state   <= IDLE;
                        tone_en <= 1'b0;
                        busy    <= 1'b0;
                    end else if (tick_cnt != TICK_LAST) begin
                        tick_cnt  <= tick_cnt + 1'b1;
                        // registered, so raise it entering the final cycle
                        note_done <= (dur_cnt == ONE) &&
                                     (tick_cnt == TICK_PRE);
                    end else begin
                        tick_cnt <= '0;
                        dur_cnt  <= dur_cnt - 1'b1;
                        if (dur_cnt == ONE) begin
                            tone_en <= 1'b0;
`ifdef TONE_SEQ_GAP_EN
                            state   <= GAP;
                            gap_cnt <= '0;
`else
                            state   <= more ? LOAD : IDLE;
                            busy    <= more;
`endif
                        end
                    end
                end
`ifdef TONE_SEQ_GAP_EN
                GAP: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (gap_cnt == GAP_LAST) begin
                        state <= more ? LOAD : IDLE;
                        busy  <= more;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
`else
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
`endif
            endcase
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with a segment-level reference
// model compared every cycle, plus hand-computed literal checks.
module tb_tone_sequencer;

    localparam int TD      = 4;
    localparam int DEPTH   = 4;
    localparam int GAP_CYC = 3;
`ifdef TONE_SEQ_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif
    localparam int GAPLEN = GAP_ON ? GAP_CYC + 1 : 1;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_PLAY = 2;
    localparam int M_GAP  = 3;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        note_valid = 1'b0;
    logic        start      = 1'b0;
    logic        stop       = 1'b0;
    logic [7:0]  note_slope = '0;
    logic [15:0] note_dur   = '0;
    logic        note_ready;
    logic        tone_en;
    logic        note_done;
    logic        busy;
    logic [7:0]  invslope;
    logic [2:0]  level;

    tone_sequencer #(
        .DEPTH    (DEPTH),
        .TICK_DIV (TD),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note_slope (note_slope),
        .note_dur   (note_dur),
        .start      (start),
        .stop       (stop),
        .invslope   (invslope),
        .tone_en    (tone_en),
        .note_done  (note_done),
        .busy       (busy),
        .level      (level)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Reference: the sequencer as a list of segments, each a countdown
    int m_seg   = M_IDLE;
    int m_left  = 0;
    bit m_run   = 1'b0;
    int m_slope = 0;
    int q_s[$];
    int q_d[$];

    task automatic model_reset();
        m_seg   = M_IDLE;
        m_left  = 0;
        m_run   = 1'b0;
        m_slope = 0;
        q_s.delete();
        q_d.delete();
    endtask

    task automatic model_step();
        bit rn;
        bit has;
        bit psh;
        int s;
        int d;
        if (rst_n) begin
            rn  = (m_run || start) && !stop;
            has = q_s.size() > 0;
            psh = note_valid && (q_s.size() < DEPTH);
            case (m_seg)
                M_IDLE: if (rn && has) m_seg = M_LOAD;
                M_LOAD: begin
                    s = q_s.pop_front();
                    d = q_d.pop_front();
                    if (stop) m_seg = M_IDLE;
                    else begin
                        m_seg   = M_PLAY;
                        m_slope = s;
                        m_left  = ((d == 0) ? 1 : d) * TD;
                    end
                end
                M_PLAY: begin
                    if (stop) m_seg = M_IDLE;
                    else if (m_left > 1) m_left--;
                    else if (GAP_ON) begin
                        m_seg  = M_GAP;
                        m_left = GAP_CYC;
                    end else m_seg = (rn && has) ? M_LOAD : M_IDLE;
                end
                default: begin
                    if (stop) m_seg = M_IDLE;
                    else if (m_left > 1) m_left--;
                    else m_seg = (rn && has) ? M_LOAD : M_IDLE;
                end
            endcase
            if (psh) begin
                q_s.push_back(int'(note_slope));
                q_d.push_back(int'(note_dur));
            end
            m_run = rn;
        end
    endtask

    int on_total   = 0;
    int done_total = 0;
    int low_run    = 0;
    bit seen_high  = 1'b0;
    int gaps[$];

    initial forever begin
        @(negedge clk);
        check("tone_en", 32'(tone_en), 32'(m_seg == M_PLAY));
        check("note_done", 32'(note_done),
              32'(m_seg == M_PLAY && m_left == 1));
        check("busy", 32'(busy), 32'(m_seg != M_IDLE));
        check("invslope", 32'(invslope), 32'(m_slope));
        check("level", 32'(level), 32'(q_s.size()));
        check("note_ready", 32'(note_ready), 32'(q_s.size() < DEPTH));
        if (tone_en === 1'b1) begin
            on_total++;
            if (seen_high && low_run > 0) gaps.push_back(low_run);
            low_run   = 0;
            seen_high = 1'b1;
        end else if (seen_high) begin
            low_run++;
        end
        if (note_done === 1'b1) done_total++;
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic offer(input int s, input int d);
        bit got;
        got        = 1'b0;
        note_valid = 1'b1;
        note_slope = 8'(s);
        note_dur   = 16'(d);
        for (int k = 0; k < 200 && !got; k++) begin
            got = note_ready;
            tick();
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL offer_timeout: slope %0d never accepted", s);
        end
    endtask

    task automatic push_note(input int s, input int d);
        offer(s, d);
        note_valid = 1'b0;
    endtask

    task automatic reset_vals(input string tag);
        check({tag, "_tone_en"}, 32'(tone_en), 0);
        check({tag, "_invslope"}, 32'(invslope), 0);
        check({tag, "_note_done"}, 32'(note_done), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_level"}, 32'(level), 0);
        check({tag, "_note_ready"}, 32'(note_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int on0;
        int d0;
        int g0;
        int gmin;
        int gmax;
        model_reset();
        ticks(3);
        reset_vals("por");
        rst_n = 1'b1;
        tick();

        // single note slope 10, 2 ticks
        push_note(10, 2);
        check("s2_level_queued", 32'(level), 1);
        check("s2_idle_no_run", 32'(busy), 0);
        on0 = on_total;
        d0  = done_total;
        pulse_start();
        check("s2_load_busy", 32'(busy), 1);
        check("s2_load_silent", 32'(tone_en), 0);
        tick();
        check("s2_play_on", 32'(tone_en), 1);
        check("s2_slope", 32'(invslope), 10);
        ticks(20);
        check("s2_on_cycles", 32'(on_total - on0), 8);
        check("s2_done_pulses", 32'(done_total - d0), 1);
        check("s2_idle_after", 32'(busy), 0);

        // queue fill with valid held, fifth accepted after the first pop
        pulse_stop();
        for (int i = 0; i < 4; i++) begin
            note_valid = 1'b1;
            note_slope = 8'(20 + i);
            note_dur   = (i == 1) ? 16'd2 : ((i == 2) ? 16'd0 : 16'd1);
            tick();
        end
        note_slope = 8'd24;
        note_dur   = 16'd1;
        ticks(2);
        check("s3_full_level", 32'(level), 4);
        check("s3_full_ready", 32'(note_ready), 0);
        on0 = on_total;
        d0  = done_total;
        g0  = gaps.size();
        pulse_start();
        check("s3_load_level", 32'(level), 4);
        check("s3_load_ready", 32'(note_ready), 0);
        tick();
        check("s3_pop_level", 32'(level), 3);
        check("s3_pop_ready", 32'(note_ready), 1);
        tick();
        check("s3_fifth_level", 32'(level), 4);
        note_valid = 1'b0;
        ticks(80);
        check("s3_on_cycles", 32'(on_total - on0), 24);
        check("s3_done_pulses", 32'(done_total - d0), 5);
        check("s3_gap_count", 32'(gaps.size() - g0), 5);
        gmin = 1000;
        gmax = 0;
        for (int i = g0 + 1; i < gaps.size(); i++) begin
            if (gaps[i] < gmin) gmin = gaps[i];
            if (gaps[i] > gmax) gmax = gaps[i];
        end
        check("s3_gap_min", 32'(gmin), 32'(GAPLEN));
        check("s3_gap_max", 32'(gmax), 32'(GAPLEN));
        check("s3_last_slope", 32'(invslope), 24);
        check("s3_drained", 32'(level), 0);

        // stop mid-note with two queued, then resume
        offer(30, 3);
        offer(31, 3);
        offer(32, 3);
        note_valid = 1'b0;
        ticks(3);
        check("s5_playing", 32'(tone_en), 1);
        check("s5_level", 32'(level), 2);
        d0 = done_total;
        pulse_stop();
        check("s5_stop_silent", 32'(tone_en), 0);
        check("s5_stop_idle", 32'(busy), 0);
        check("s5_kept", 32'(level), 2);
        ticks(5);
        check("s5_no_done", 32'(done_total - d0), 0);
        on0 = on_total;
        d0  = done_total;
        pulse_start();
        ticks(60);
        check("s5_on_cycles", 32'(on_total - on0), 24);
        check("s5_done_pulses", 32'(done_total - d0), 2);
        check("s5_last_slope", 32'(invslope), 32);
        check("s5_drained", 32'(level), 0);

        // start and stop together, then a zero-duration note
        pulse_stop();
        push_note(40, 0);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        ticks(3);
        check("s6_stays_idle", 32'(busy), 0);
        check("s6_silent", 32'(tone_en), 0);
        check("s6_queued", 32'(level), 1);
        on0 = on_total;
        d0  = done_total;
        pulse_start();
        ticks(15);
        check("s6_dur0_cycles", 32'(on_total - on0), 4);
        check("s6_dur0_done", 32'(done_total - d0), 1);
        check("s6_slope", 32'(invslope), 40);

        // asynchronous reset in the middle of a note
        push_note(50, 5);
        ticks(4);
        check("s1_playing", 32'(tone_en), 1);
        check("s1_slope", 32'(invslope), 50);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        reset_vals("async");
        tick();
        rst_n = 1'b1;
        ticks(5);
        check("s1_idle_after", 32'(busy), 0);
        check("s1_silent_after", 32'(tone_en), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
